// File: rtl/twiddle_angle_gen.sv
// FFT twiddle angle generator: streams theta(k) = -2*pi*k/N as IEEE floats for k = 0..N/2-1
// through a two-stage valid/ready pipeline (stage 1: fixed-point magnitude, stage 2: float pack).
module twiddle_angle_gen #(
    parameter int unsigned double    = 0,
    parameter int unsigned LOG2N_MAX = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               start,
    input  logic [4:0]                         log2n,
    output logic [((double != 0) ? 64 : 32)-1:0] theta,
    output logic [LOG2N_MAX-2:0]               k_out,
    output logic                               theta_valid,
    input  logic                               theta_ready,
    output logic                               last,
    output logic                               busy,
    output logic                               done,
    output logic                               err
);

    localparam int unsigned SIZE = (double != 0) ? 64 : 32;
    localparam int unsigned KW   = LOG2N_MAX - 1;
    localparam int unsigned PW   = KW + SIZE;
    localparam int unsigned FW   = (double != 0) ? 52 : 23;
    localparam int unsigned EW   = (double != 0) ? 11 : 8;
    localparam int unsigned BIAS = (double != 0) ? 1023 : 127;
    localparam int unsigned PBW  = 7;

    localparam logic [63:0]     C_SEL = (double != 0) ? 64'hC90FDAA22168C234 : 64'h00000000C90FDAA2;
    localparam logic [SIZE-1:0] C_2PI = SIZE'(C_SEL);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            w_err_nxt;
    logic            w_done_nxt;

    logic [4:0]      r_log2n;
    logic [KW-1:0]   r_k;
    logic [KW-1:0]   w_k_last;
    logic            r_busy;
    logic            r_done;
    logic            r_err;

    logic            r_s1_v;
    logic            r_s1_last;
    logic [KW-1:0]   r_s1_k;
    logic [SIZE-1:0] r_s1_mag;

    logic            r_s2_v;
    logic            r_s2_last;
    logic [KW-1:0]   r_s2_k;
    logic [SIZE-1:0] r_theta;

    logic            w_en;
    logic            w_start_ok;
    logic            w_issue;
    logic            w_issue_last;
    logic            w_xfer_last;
    logic [PW-1:0]   w_prod;
    logic [SIZE-1:0] w_mag;
    logic [PBW-1:0]  w_p;
    logic [SIZE-1:0] w_norm;
    logic [EW-1:0]   w_exp;
    logic [FW-1:0]   w_frac;
    logic [SIZE-1:0] w_theta;

    // The whole pipe freezes only while an item is presented and refused.
    assign w_en         = !(r_s2_v && !theta_ready);
    assign w_start_ok   = start && (log2n != 5'd0) && (log2n <= 5'(LOG2N_MAX));
    assign w_k_last     = KW'((32'd1 << (r_log2n - 5'd1)) - 32'd1);
    assign w_issue      = (r_state == S_RUN) && w_en;
    assign w_issue_last = w_issue && (r_k == w_k_last);
    assign w_xfer_last  = r_s2_v && theta_ready && r_s2_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_err_nxt   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = S_RUN;
                end else if (start) begin
                    w_err_nxt = 1'b1;
                end
            end
            S_RUN: begin
                if (w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_xfer_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Sequence control: latched size, k counter and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_log2n <= 5'd0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if ((r_state == S_IDLE) && w_start_ok) begin
                r_log2n <= log2n;
                r_k     <= '0;
            end else if (w_issue && !w_issue_last) begin
                r_k <= r_k + KW'(1);
            end
        end
    end

    // Magnitude in Q3.(SIZE-3); k < N/2 keeps the shifted product below pi, so it fits SIZE bits.
    assign w_prod = PW'(r_k) * PW'(C_2PI);
    assign w_mag  = SIZE'(w_prod >> r_log2n);

    always_comb begin
        w_p = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            if (r_s1_mag[i]) begin
                w_p = PBW'(i);
            end
        end
        w_norm  = r_s1_mag << (PBW'(SIZE - 1) - w_p);
        w_exp   = EW'(int'(BIAS) + int'(w_p) - int'(SIZE - 3));
        w_frac  = FW'(w_norm >> (SIZE - 1 - FW));
        w_theta = (r_s1_mag == '0) ? '0 : {1'b1, w_exp, w_frac};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_v    <= 1'b0;
            r_s1_last <= 1'b0;
            r_s1_k    <= '0;
            r_s1_mag  <= '0;
            r_s2_v    <= 1'b0;
            r_s2_last <= 1'b0;
            r_s2_k    <= '0;
            r_theta   <= '0;
        end else if (w_en) begin
            r_s1_v    <= (r_state == S_RUN);
            r_s1_last <= (r_k == w_k_last);
            r_s1_k    <= r_k;
            r_s1_mag  <= w_mag;
            r_s2_v    <= r_s1_v;
            if (r_s1_v) begin
                r_s2_last <= r_s1_last;
                r_s2_k    <= r_s1_k;
                r_theta   <= w_theta;
            end
        end
    end

    assign theta       = r_theta;
    assign k_out       = r_s2_k;
    assign theta_valid = r_s2_v;
    assign last        = r_s2_last;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;

endmodule

// File: tb/tb_twiddle_angle_gen.sv
// Randomized bench for twiddle_angle_gen: single and double instances driven in lockstep,
// checked against an arithmetic model of theta(k) and the sequencing rules.
module tb_twiddle_angle_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  log2n;
    logic        ready;

    logic [31:0] theta0;
    logic [63:0] theta1;
    logic [8:0]  k0, k1;
    logic        valid0, valid1, last0, last1, busy0, busy1, done0, done1, err0, err1;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] gold3 [4] = '{32'h00000000, 32'hBF490FDA, 32'hBFC90FDA, 32'hC016CBE3};

    always #5 clk = ~clk;

    twiddle_angle_gen #(.double(0), .LOG2N_MAX(10)) u_sgl (
        .clk(clk), .rst(rst), .start(start), .log2n(log2n),
        .theta(theta0), .k_out(k0), .theta_valid(valid0), .theta_ready(ready),
        .last(last0), .busy(busy0), .done(done0), .err(err0)
    );

    twiddle_angle_gen #(.double(1), .LOG2N_MAX(10)) u_dbl (
        .clk(clk), .rst(rst), .start(start), .log2n(log2n),
        .theta(theta1), .k_out(k1), .theta_valid(valid1), .theta_ready(ready),
        .last(last1), .busy(busy1), .done(done1), .err(err1)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // theta = -(k*2pi/N) built from integer magnitude, exponent and truncated fraction.
    function automatic logic [63:0] model(input int ln, input int k, input bit dbl);
        logic [127:0] c, mag, rem, frac;
        int size, fw, bias, p, e;
        size = dbl ? 64 : 32;
        fw   = dbl ? 52 : 23;
        bias = dbl ? 1023 : 127;
        c    = dbl ? 128'hC90FDAA22168C234 : 128'hC90FDAA2;
        mag  = (c * 128'(k)) >> ln;
        if (mag == 0) return 64'd0;
        p = 0;
        while ((mag >> (p + 1)) != 0) p++;
        rem  = mag - (128'd1 << p);
        frac = (p >= fw) ? (rem >> (p - fw)) : (rem << (fw - p));
        e    = bias + p - (size - 3);
        if (dbl) return {1'b1, 11'(e), frac[51:0]};
        return {32'd0, 1'b1, 8'(e), frac[22:0]};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_theta0"}, 64'(theta0), 64'd0);
        check_eq({tag, "_theta1"}, theta1, 64'd0);
        check_eq({tag, "_k"}, 64'(k0), 64'd0);
        check_eq({tag, "_valid"}, 64'({valid0, valid1}), 64'd0);
        check_eq({tag, "_last"}, 64'({last0, last1}), 64'd0);
        check_eq({tag, "_busy"}, 64'({busy0, busy1}), 64'd0);
        check_eq({tag, "_done"}, 64'({done0, done1}), 64'd0);
        check_eq({tag, "_err"}, 64'({err0, err1}), 64'd0);
    endtask

    // mode 0: ready high, 1: 4-cycle stall on k=1, 2: random ready + stray starts, 3: ready high with reset at abort_k
    task automatic run_seq(input int ln, input int mode, input int abort_k);
        int n, exp_k, cyc, stalls;
        bit first, held, fin, aborted;
        logic [31:0] h_t;
        logic [8:0]  h_k;
        n = 1 << (ln - 1);
        exp_k = 0; cyc = 0; stalls = 0;
        first = 1'b1; held = 1'b0; fin = 1'b0; aborted = 1'b0;
        h_t = '0; h_k = '0;
        @(negedge clk);
        log2n = 5'(ln);
        start = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("busy_after_start", 64'(busy0), 64'd1);
        check_eq("latency_e1", 64'(valid0), 64'd0);
        @(negedge clk);
        check_eq("latency_e2", 64'(valid0), 64'd0);
        while (!fin && !aborted) begin
            @(negedge clk);
            if (first) begin
                check_eq("latency_first_valid", 64'(valid0), 64'd1);
                first = 1'b0;
            end
            if (held) begin
                check_eq("stall_theta", 64'(theta0), 64'(h_t));
                check_eq("stall_k", 64'(k0), 64'(h_k));
            end
            check_eq("no_err_busy", 64'(err0 | err1), 64'd0);
            if (abort_k >= 0 && exp_k == abort_k) begin
                rst = 1'b1;
                aborted = 1'b1;
            end else begin
                case (mode)
                    1: begin
                        ready = !(valid0 && k0 == 9'd1 && stalls < 4);
                        if (!ready) stalls++;
                    end
                    2: ready = ($urandom_range(0, 3) != 0);
                    default: ready = 1'b1;
                endcase
                if (mode == 2) begin
                    start = 1'($urandom_range(0, 1));
                    log2n = 5'($urandom_range(0, 15));
                end
                if (valid0 && ready) begin
                    check_eq("theta_sgl", 64'(theta0), model(ln, exp_k, 1'b0));
                    check_eq("theta_dbl", theta1, model(ln, exp_k, 1'b1));
                    check_eq("k_out", 64'({k0, k1}), 64'({9'(exp_k), 9'(exp_k)}));
                    check_eq("last", 64'({last0, last1}), (exp_k == n - 1) ? 64'd3 : 64'd0);
                    check_eq("valid_dbl", 64'(valid1), 64'd1);
                    if (ln == 3 && exp_k < 4) check_eq("gold_sgl_n8", 64'(theta0), 64'(gold3[exp_k]));
                    if (ln == 3 && exp_k == 2) check_eq("gold_dbl_n8_k2", theta1, 64'hBFF921FB54442D18);
                    if (ln == 2 && exp_k == 1) check_eq("gold_sgl_n4_k1", 64'(theta0), 64'hBFC90FDA);
                    if (exp_k == n - 1) fin = 1'b1;
                    exp_k++;
                    held = 1'b0;
                end else if (valid0) begin
                    held = 1'b1;
                    h_t = theta0;
                    h_k = k0;
                end else begin
                    held = 1'b0;
                end
            end
            cyc++;
            if (cyc > 4 * n + 20 && !fin && !aborted) begin
                n_vec++;
                n_bad++;
                $display("FAIL timeout: got %0d transfers expected %0d", exp_k, n);
                fin = 1'b1;
            end
        end
        start = 1'b0;
        ready = 1'b1;
        @(negedge clk);
        if (aborted) begin
            rst = 1'b0;
            check_reset_outputs("reset_mid");
            repeat (3) begin
                @(negedge clk);
                check_eq("no_done_after_reset", 64'({done0, done1, valid0, busy0}), 64'd0);
            end
        end else begin
            check_eq("done_pulse", 64'({done0, done1}), 64'd3);
            check_eq("busy_fall", 64'({busy0, busy1}), 64'd0);
            check_eq("valid_drop", 64'({valid0, valid1}), 64'd0);
            @(negedge clk);
            check_eq("done_one_cycle", 64'({done0, done1}), 64'd0);
        end
    endtask

    task automatic err_test(input int ln);
        @(negedge clk);
        log2n = 5'(ln);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("err_pulse", 64'({err0, err1}), 64'd3);
        check_eq("err_busy", 64'({busy0, busy1}), 64'd0);
        check_eq("err_valid", 64'({valid0, valid1}), 64'd0);
        @(negedge clk);
        check_eq("err_clear", 64'({err0, err1}), 64'd0);
        check_eq("err_stay_idle", 64'({busy0, valid0}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        log2n = 5'd0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        run_seq(3, 0, -1);
        run_seq(2, 0, -1);
        run_seq(3, 1, -1);
        err_test(0);
        err_test(11);
        run_seq(10, 3, 100);
        run_seq(10, 0, -1);
        run_seq(1, 0, -1);
        for (int i = 0; i < 6; i++) begin
            run_seq(int'($urandom_range(1, 10)), 2, -1);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
